// File: rtl/fifo_axis_reader.sv
// Drains an async_fifo read port into an AXI4-Stream master. A head+skid pair
// absorbs the FIFO's one-cycle read latency so tready can stall without loss.
module fifo_axis_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int PKT_LEN    = 0
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  busy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam logic        HAS_LAST = (PKT_LEN != 0);
   localparam logic [15:0] LAST_IDX = (PKT_LEN == 0) ? 16'd0 : 16'(PKT_LEN - 1);

   occ_e                  occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic [15:0]           cnt_q, cnt_d;

   logic       pop;
   logic       cap;
   logic [2:0] fill;
   logic       room;

   assign pop  = tvalid_q && m_axis_tready;
   assign cap  = inflight_q;
   assign fill = {1'b0, occ_q} + {2'b00, inflight_q};
   // Buffered plus in-flight words, less this cycle's pop, must leave a free slot.
   assign room = fill < (3'd2 + {2'b00, pop});

   assign fifo_rd_en    = rd_rst_n && en && !fifo_empty && room;
   assign m_axis_tdata  = head_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = inflight_q || tvalid_q;

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      skid_d = skid_q;
      case (occ_q)
         EMPTY: begin
            if (cap) begin
               head_d = fifo_dout;
               occ_d  = ONE;
            end
         end
         ONE: begin
            if (cap && pop) begin
               head_d = fifo_dout;
            end else if (cap) begin
               skid_d = fifo_dout;
               occ_d  = TWO;
            end else if (pop) begin
               occ_d  = EMPTY;
            end
         end
         TWO: begin
            // The issue rule guarantees no capture arrives here without a pop.
            if (pop) begin
               head_d = skid_q;
               if (cap) skid_d = fifo_dout;
               else     occ_d  = ONE;
            end
         end
         default: occ_d = EMPTY;
      endcase
   end

   always_comb begin
      inflight_d = fifo_rd_en;
      tvalid_d   = (occ_d != EMPTY);
      cnt_d      = cnt_q;
      if (pop) cnt_d = tlast_q ? 16'd0 : 16'(cnt_q + 16'd1);
      tlast_d    = HAS_LAST && tvalid_d && (cnt_d == LAST_IDX);
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         occ_q      <= EMPTY;
         inflight_q <= 1'b0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
         cnt_q      <= 16'd0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Random and directed stimulus for fifo_axis_reader against a queue-based FIFO
// model and a word/beat scoreboard.
module tb_fifo_axis_reader;
   localparam int DW = 32;
   localparam int PL = 4;

   logic          rd_clk = 1'b0;
   logic          rd_rst_n = 1'b0;
   logic          en = 1'b0;
   logic          gap = 1'b0;
   logic          tready = 1'b0;
   logic          fifo_empty, fifo_rd_en, tvalid, tlast, busy;
   logic [DW-1:0] fifo_dout = '0;
   logic [DW-1:0] tdata;

   always #5 rd_clk = ~rd_clk;

   logic [DW-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];
   int push_n = 0;
   int popf_n = 0;

   assign fifo_empty = gap || (push_n == popf_n);

   fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
      .rd_clk       (rd_clk),
      .rd_rst_n     (rd_rst_n),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_dout    (fifo_dout),
      .fifo_rd_en   (fifo_rd_en),
      .m_axis_tdata (tdata),
      .m_axis_tvalid(tvalid),
      .m_axis_tlast (tlast),
      .m_axis_tready(tready),
      .busy         (busy)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // model state
   logic fire_pend = 1'b0;
   int   cyc = 0, reads = 0, pops = 0, beat = 0, tl_cnt = 0;
   logic prev_fire = 1'b0, prev_stall = 1'b0, prev_last = 1'b0, prev_busy = 1'b0;
   logic [DW-1:0] prev_data = '0;
   int   rd_t, pop_t, first_rd, last_rd, first_pop, last_pop, first_vld, busy_fall, max_buf;

   // FIFO model: a word fires out on the edge after rd_en && !empty
   always @(posedge rd_clk) begin : fifo_model
      logic [DW-1:0] w;
      if (rd_rst_n && fire_pend) begin
         w = src_q.pop_front();
         exp_q.push_back(w);
         fifo_dout <= w;
         popf_n    <= popf_n + 1;
      end
   end

   always @(negedge rd_clk) begin : monitor
      int   outst;
      logic fire, pp;
      if (!rd_rst_n) begin
         fire_pend  = 1'b0;
         prev_fire  = 1'b0;
         prev_stall = 1'b0;
         prev_busy  = 1'b0;
      end else begin
         cyc++;
         outst = reads - pops;
         fire  = fifo_rd_en && !fifo_empty;
         pp    = tvalid && tready;
         chk("rd_when_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
         chk("rd_en_rule", 32'(fifo_rd_en), 32'(en && !fifo_empty && (outst - int'(pp) < 2)));
         chk("tvalid", 32'(tvalid), 32'((outst - int'(prev_fire)) != 0));
         chk("busy", 32'(busy), 32'(outst != 0));
         if (outst - int'(prev_fire) > max_buf) max_buf = outst - int'(prev_fire);
         if (prev_stall) begin
            chk("hold_data", tdata, prev_data);
            chk("hold_last", 32'(tlast), 32'(prev_last));
         end
         if (pp) begin
            if (exp_q.size() == 0) chk("pop_underflow", 32'(exp_q.size()), 32'd1);
            else                   chk("tdata", tdata, exp_q.pop_front());
            chk("tlast", 32'(tlast), 32'((beat % PL) == PL - 1));
            if (tlast) tl_cnt++;
            beat++;
            pops++;
            pop_t++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         if (fire) begin
            reads++;
            rd_t++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
         end
         if (tvalid && first_vld < 0) first_vld = cyc;
         if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc;
         prev_fire  = fire;
         fire_pend  = fire;
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
         prev_busy  = busy;
      end
   end

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] w);
      src_q.push_back(w);
      push_n++;
   endtask

   task automatic clear_stats();
      rd_t = 0; pop_t = 0; tl_cnt = 0; max_buf = 0;
      first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
      first_vld = -1; busy_fall = -1;
   endtask

   // Model side of a reset: the FIFO is reset alongside the reader.
   task automatic clear_model();
      src_q.delete();
      exp_q.delete();
      push_n = popf_n;
      reads = 0;
      pops = 0;
      beat = 0;
   endtask

   task automatic do_reset();
      tick();
      rd_rst_n = 1'b0;
      en = 1'b0; tready = 1'b0; gap = 1'b0;
      clear_model();
      tick();
      tick();
      rd_rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      int t;
      en = 1'b1; tready = 1'b1; gap = 1'b0;
      t = 0;
      repeat (3) tick();
      while (t < 300 && !((push_n == popf_n) && reads == pops && !fire_pend)) begin
         tick();
         t++;
      end
      repeat (2) tick();
      chk(tag, 32'(reads - pops), 32'd0);
   endtask

   task automatic wait_cnt(input int which, input int target);
      int t;
      t = 0;
      while (t < 100 && ((which == 0) ? rd_t : pop_t) < target) begin
         @(negedge rd_clk);
         #1;
         t++;
      end
      chk("wait_timeout", 32'(t < 100), 32'd1);
   endtask

   initial begin
      clear_stats();
      // reset with random inputs
      repeat (4) begin
         tick();
         en     = 1'($urandom_range(1));
         tready = 1'($urandom_range(1));
         gap    = 1'($urandom_range(1));
         push($urandom);
         @(negedge rd_clk);
         chk("rst_tvalid", 32'(tvalid), 32'd0);
         chk("rst_tdata", tdata, 32'd0);
         chk("rst_tlast", 32'(tlast), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      end
      do_reset();

      // streaming at full rate
      tick();
      clear_stats();
      for (int i = 1; i <= 8; i++) push(DW'(i));
      en = 1'b1; tready = 1'b1;
      drain("stream_drain");
      chk("stream_reads", 32'(rd_t), 32'd8);
      chk("stream_pops", 32'(pop_t), 32'd8);
      chk("stream_latency", 32'(first_vld - first_rd), 32'd2);
      chk("stream_rd_span", 32'(last_rd - first_rd), 32'd7);
      chk("stream_pop_span", 32'(last_pop - first_pop), 32'd7);
      chk("stream_tlasts", 32'(tl_cnt), 32'd2);

      // backpressure mid-stream
      do_reset();
      clear_stats();
      for (int i = 1; i <= 8; i++) push(DW'(i));
      en = 1'b1; tready = 1'b1;
      wait_cnt(1, 2);
      tick();
      tready = 1'b0;
      repeat (5) tick();
      tready = 1'b1;
      drain("bp_drain");
      chk("bp_reads", 32'(rd_t), 32'd8);
      chk("bp_pops", 32'(pop_t), 32'd8);
      chk("bp_max_buffered", 32'(max_buf), 32'd2);

      // packets with random tready
      do_reset();
      clear_stats();
      for (int i = 0; i < 10; i++) push($urandom);
      en = 1'b1;
      for (int t = 0; t < 300 && pop_t < 10; t++) begin
         tick();
         tready = 1'($urandom_range(1));
      end
      drain("pkt_drain");
      chk("pkt_pops", 32'(pop_t), 32'd10);
      chk("pkt_tlasts", 32'(tl_cnt), 32'd2);

      // en drop after three reads; beat counter continues from 2
      clear_stats();
      for (int i = 0; i < 10; i++) push($urandom);
      tready = 1'b1; en = 1'b1;
      wait_cnt(0, 3);
      tick();
      en = 1'b0;
      repeat (10) tick();
      chk("endrop_reads", 32'(rd_t), 32'd3);
      chk("endrop_pops", 32'(pop_t), 32'd3);
      chk("endrop_tlasts", 32'(tl_cnt), 32'd1);
      chk("endrop_busy_fall", 32'(busy_fall - last_pop), 32'd1);
      do_reset();

      // random empty gaps, enables and backpressure
      clear_stats();
      for (int i = 0; i < 400; i++) begin
         tick();
         gap    = ($urandom_range(2) == 0);
         en     = ($urandom_range(4) != 0);
         tready = ($urandom_range(2) != 0);
         if ($urandom_range(1) == 1) push($urandom);
      end
      drain("gap_drain");
      chk("gap_fifo_drained", 32'(push_n - popf_n), 32'd0);
      chk("gap_scoreboard", 32'(exp_q.size()), 32'd0);

      // async reset while both slots are full
      tready = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) push($urandom);
      repeat (6) tick();
      chk("prerst_buffered", 32'(reads - pops), 32'd2);
      chk("prerst_tvalid", 32'(tvalid), 32'd1);
      @(posedge rd_clk);
      #3;
      rd_rst_n = 1'b0;
      #1;
      chk("arst_tvalid", 32'(tvalid), 32'd0);
      chk("arst_tdata", tdata, 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
      en = 1'b0;
      clear_model();
      tick();
      tick();
      rd_rst_n = 1'b1;
      tick();
      clear_stats();
      for (int i = 0; i < 6; i++) push(DW'(32'hA0 + i));
      drain("post_rst_drain");
      chk("post_rst_pops", 32'(pop_t), 32'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
      $fatal(1, "watchdog");
   end

endmodule
